// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends it as
// start bit, LSB-first data, optional odd/even parity and 1..2 stop bits.
module uart_tx #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BURD_RATE  = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_CHECK_ON   = 1,
    parameter int P_UART_STOP_WIDTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_uart_tx,
    output logic                         o_tx_busy
);

    localparam int          BIT_CYC    = P_SYSTEM_CLK / P_UART_BURD_RATE;
    localparam logic [15:0] BAUD_LAST  = 16'(BIT_CYC - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(P_UART_STOP_WIDTH - 1);
    localparam bit          HAS_PARITY = (P_UART_CHECK_ON != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                       state, state_nxt;
    logic [15:0]                  baud_cnt, baud_nxt;
    logic [3:0]                   bit_idx, idx_nxt;
    logic [P_UART_DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic                         parity_bit, parity_nxt;
    logic                         tx_reg, tx_nxt;
    logic                         ready_reg, ready_nxt;
    logic                         busy_reg;
    logic                         bit_end;

    function automatic logic frame_parity(input logic [P_UART_DATA_WIDTH-1:0] d);
        return (P_UART_CHECK_ON == 2) ? ^d : ~^d;
    endfunction

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= idx_nxt;
            shift_reg  <= shift_nxt;
            parity_bit <= parity_nxt;
            tx_reg     <= tx_nxt;
            ready_reg  <= ready_nxt;
            busy_reg   <= ~ready_nxt;
        end
    end

    // Line level and ready are computed one cycle ahead so the outputs come straight from flops.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        idx_nxt    = bit_idx;
        shift_nxt  = shift_reg;
        parity_nxt = parity_bit;
        tx_nxt     = tx_reg;
        ready_nxt  = ready_reg;

        if (state != IDLE) begin
            baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                baud_nxt  = '0;
                idx_nxt   = '0;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                if (i_user_tx_valid && ready_reg) begin
                    shift_nxt  = i_user_tx_data;
                    parity_nxt = frame_parity(i_user_tx_data);
                    state_nxt  = START;
                    tx_nxt     = 1'b0;
                    ready_nxt  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_nxt = '0;
                        if (HAS_PARITY) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt = bit_idx + 4'd1;
                        tx_nxt  = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        tx_nxt    = 1'b1;
                        ready_nxt = 1'b1;
                    end else begin
                        idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_uart_tx       = tx_reg;
    assign o_user_tx_ready = ready_reg;
    assign o_tx_busy       = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (odd/1 stop, even, none, odd/2 stop) at 10 clocks per bit,
// with a per-lane line decoder that checks every received frame against queued expectations.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld [4];
    logic       rdy [4];
    logic       txl [4];
    logic       bsy [4];
    logic [7:0] dat [4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       par;
        int         gap;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)) dut_odd (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(dat[0]), .i_user_tx_valid(vld[0]),
        .o_user_tx_ready(rdy[0]), .o_uart_tx(txl[0]), .o_tx_busy(bsy[0]));

    uart_tx #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1)) dut_even (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(dat[1]), .i_user_tx_valid(vld[1]),
        .o_user_tx_ready(rdy[1]), .o_uart_tx(txl[1]), .o_tx_busy(bsy[1]));

    uart_tx #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1)) dut_none (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(dat[2]), .i_user_tx_valid(vld[2]),
        .o_user_tx_ready(rdy[2]), .o_uart_tx(txl[2]), .o_tx_busy(bsy[2]));

    uart_tx #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(2)) dut_stop2 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(dat[3]), .i_user_tx_valid(vld[3]),
        .o_user_tx_ready(rdy[3]), .o_uart_tx(txl[3]), .o_tx_busy(bsy[3]));

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, expv);
        end
    endtask

    // Decodes frames on one lane; each bit must hold for exactly 10 clocks.
    task automatic monitor(input int lane, input int chk, input int stp);
        int         n;
        int         start_cyc;
        int         last_start;
        logic [11:0] bits;
        logic       prev;
        logic       stop_ok;
        bit         stable, rdy_low, bsy_hi;
        exp_t       e;
        n          = 1 + 8 + ((chk != 0) ? 1 : 0) + stp;
        prev       = 1'b1;
        last_start = -100000;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txl[lane] === 1'b0) begin
                start_cyc = cyc;
                stable    = 1'b1;
                rdy_low   = 1'b1;
                bsy_hi    = 1'b1;
                bits      = '0;
                for (int k = 0; k < n; k++) begin
                    for (int c = 0; c < 10; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (c == 0) bits[k] = txl[lane];
                        else if (txl[lane] !== bits[k]) stable = 1'b0;
                        if (rdy[lane] !== 1'b0) rdy_low = 1'b0;
                        if (bsy[lane] !== 1'b1) bsy_hi = 1'b0;
                    end
                end
                @(negedge clk);
                stop_ok = 1'b1;
                for (int j = n - stp; j < n; j++) stop_ok &= bits[j];
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame lane%0d: got data 0x%0h, required no frame",
                             lane, bits[8:1]);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.abort) begin
                        check($sformatf("lane%0d_owner", lane), lane, e.lane);
                        check($sformatf("lane%0d_start_bit", lane), int'(bits[0]), 0);
                        check($sformatf("lane%0d_data", lane), int'(bits[8:1]), int'(e.data));
                        if (chk != 0)
                            check($sformatf("lane%0d_parity", lane), int'(bits[9]), int'(e.par));
                        check($sformatf("lane%0d_stop_bits", lane), int'(stop_ok), 1);
                        check($sformatf("lane%0d_bit_stable", lane), int'(stable), 1);
                        check($sformatf("lane%0d_ready_low_frame", lane), int'(rdy_low), 1);
                        check($sformatf("lane%0d_busy_high_frame", lane), int'(bsy_hi), 1);
                        check($sformatf("lane%0d_frame_end_tx_rdy_bsy", lane),
                              int'({txl[lane], rdy[lane], bsy[lane]}), 3'b110);
                        if (e.gap != 0)
                            check($sformatf("lane%0d_start_gap", lane), start_cyc - last_start, e.gap);
                    end
                end
                last_start = start_cyc;
            end
            prev = txl[lane];
        end
    endtask

    // Called at a negedge; presents the word until accepted, returns at the negedge after acceptance.
    task automatic send(input int lane, input logic [7:0] d, input logic p, input bit keep,
                        input int gap, input bit abort);
        exp_t e;
        int   t;
        vld[lane] = 1'b1;
        dat[lane] = d;
        t = 0;
        while (rdy[lane] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout lane%0d: ready stayed 0, required 1", lane);
            vld[lane] = 1'b0;
            return;
        end
        e.lane  = lane;
        e.data  = d;
        e.par   = p;
        e.gap   = gap;
        e.abort = abort;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) vld[lane] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !(rdy[0] && rdy[1] && rdy[2] && rdy[3])) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d frames outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial monitor(0, 1, 1);
    initial monitor(1, 2, 1);
    initial monitor(2, 0, 1);
    initial monitor(3, 1, 2);

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_lane%0d_tx_rdy_bsy", i), int'({txl[i], rdy[i], bsy[i]}), 3'b110);
        rst = 1'b0;
        @(negedge clk);

        send(0, 8'h55, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();
        send(1, 8'h80, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();
        send(2, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
        wait_idle();

        send(0, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        send(0, 8'hFF, 1'b1, 1'b0, 111, 1'b0);
        wait_idle();

        send(0, 8'h3C, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (i >= 10 && i < 14) begin
                vld[0] = 1'b1;
                dat[0] = 8'hC3;
            end else begin
                vld[0] = 1'b0;
                dat[0] = 8'($urandom);
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        wait_idle();

        send(0, 8'h0F, 1'b1, 1'b0, 0, 1'b1);
        repeat (42) @(negedge clk);
        check("mid_frame_data_bit3", int'(txl[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_frame_reset_tx_rdy_bsy", int'({txl[0], rdy[0], bsy[0]}), 3'b110);

        rst    = 1'b1;
        vld[0] = 1'b1;
        dat[0] = 8'hAA;
        @(negedge clk);
        rst    = 1'b0;
        vld[0] = 1'b0;
        check("reset_beats_valid_tx_rdy_bsy", int'({txl[0], rdy[0], bsy[0]}), 3'b110);
        wait_idle();

        send(0, 8'hF0, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();
        send(3, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();

        repeat (150) @(negedge clk);
        check("frames_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
